// File: rtl/led_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// led_ctrl_pkg
// Shared types and constants for the LED mode controller.
//   mode_t    : display mode, encoded to match the 2-bit mode output
//   dir_t     : travel direction of the BOUNCE pattern
//   PAT_SEED  : single-LED starting pattern
//   PAT_TOP   : most significant LED of the 16-LED bank
//   next_mode : mode sequence PASS -> BLINK -> SHIFT -> BOUNCE -> PASS
// ----------------------------------------------------------------------------
package led_ctrl_pkg;

    typedef enum logic [1:0] {
        MODE_PASS   = 2'd0,
        MODE_BLINK  = 2'd1,
        MODE_SHIFT  = 2'd2,
        MODE_BOUNCE = 2'd3
    } mode_t;

    typedef enum logic {
        LEFT  = 1'b0,
        RIGHT = 1'b1
    } dir_t;

    localparam logic [15:0] PAT_SEED = 16'h0001;
    localparam logic [15:0] PAT_TOP  = 16'h8000;

    function automatic mode_t next_mode(input mode_t cur);
        mode_t nxt;
        case (cur)
            MODE_PASS:   nxt = MODE_BLINK;
            MODE_BLINK:  nxt = MODE_SHIFT;
            MODE_SHIFT:  nxt = MODE_BOUNCE;
            default:     nxt = MODE_PASS;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/led_mode_ctrl_tick_gen.sv
// ----------------------------------------------------------------------------
// tick_gen
// Pattern-step prescaler. Counts 0..DIV-1 (DIV = CLK_HZ/TICK_HZ) and wraps;
// tick is high for the single cycle in which the count sits at DIV-1.
// A synchronous clear restarts the count from 0 so a freshly entered mode
// always gets a full step period before its first step.
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   clr   : synchronous clear, takes priority over counting
//   tick  : one-cycle step strobe
// ----------------------------------------------------------------------------
module tick_gen #(
    parameter int unsigned CLK_HZ  = 100_000_000,
    parameter int unsigned TICK_HZ = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);

    localparam int unsigned DIV = CLK_HZ / TICK_HZ;
    localparam int unsigned CW  = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    generate
        if (DIV < 2) begin : g_div_check
            $error("tick_gen: CLK_HZ/TICK_HZ must be at least 2");
        end
    endgenerate

    logic [CW-1:0] cnt;

    // Compare against DIV-1 rather than relying on natural rollover so that
    // non-power-of-two divide ratios work.
    assign tick = (cnt == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/led_mode_ctrl.sv
// ----------------------------------------------------------------------------
// led_mode_ctrl
// Owns the user LEDs and arbitrates them between direct switch display and
// three timed patterns. A rising edge on the synchronised "next" button steps
// the mode; tick_gen supplies the pattern step strobe.
//   clk      : system clock
//   rst_n    : asynchronous active-low reset
//   sw       : slide switches (asynchronous, double-flop synchronised here)
//   btn_next : debounced button level (asynchronous, synchronised here)
//   led      : registered LED drive
//   mode     : registered current mode (0 PASS, 1 BLINK, 2 SHIFT, 3 BOUNCE)
//
// state  | meaning
// -------+--------------------------------------------------------------
// PASS   | led mirrors the synchronised switches
// BLINK  | led shows switches while phase=1, dark while phase=0
// SHIFT  | pat rotates left one place per tick, seeded from the switches
// BOUNCE | single lit LED sweeps end to end, 30-tick round trip
// ----------------------------------------------------------------------------
module led_mode_ctrl
    import led_ctrl_pkg::*;
#(
    parameter int unsigned CLK_HZ  = 100_000_000,
    parameter int unsigned TICK_HZ = 4,
    parameter int unsigned WIDTH   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] sw,
    input  logic             btn_next,
    output logic [WIDTH-1:0] led,
    output logic [1:0]       mode
);

    localparam logic [WIDTH-1:0] SEED = WIDTH'(PAT_SEED);
    localparam logic [WIDTH-1:0] TOP  = (WIDTH == 16) ? WIDTH'(PAT_TOP)
                                                      : (WIDTH'(1) << (WIDTH - 1));

    logic [WIDTH-1:0] sw_s1;
    logic [WIDTH-1:0] sw_s2;
    logic             btn_s1;
    logic             btn_s2;
    logic             btn_prev;
    logic             btn_edge;
    logic             tick;
    logic             step;

    mode_t            mode_q;
    mode_t            mode_nxt;
    dir_t             dir_q;
    dir_t             dir_nxt;
    logic [WIDTH-1:0] pat_q;
    logic [WIDTH-1:0] pat_nxt;
    logic             phase_q;
    logic             phase_nxt;
    logic [WIDTH-1:0] led_q;
    logic [WIDTH-1:0] led_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sw_s1    <= '0;
            sw_s2    <= '0;
            btn_s1   <= 1'b0;
            btn_s2   <= 1'b0;
            btn_prev <= 1'b0;
        end else begin
            sw_s1    <= sw;
            sw_s2    <= sw_s1;
            btn_s1   <= btn_next;
            btn_s2   <= btn_s1;
            btn_prev <= btn_s2;
        end
    end

    assign btn_edge = btn_s2 & ~btn_prev;

    // A mode change restarts the prescaler, so a tick landing on the same
    // cycle is dropped rather than applied to the new mode.
    assign step = tick & ~btn_edge;

    tick_gen #(
        .CLK_HZ  (CLK_HZ),
        .TICK_HZ (TICK_HZ)
    ) u_tick_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (btn_edge),
        .tick  (tick)
    );

    always_comb begin
        mode_nxt  = mode_q;
        dir_nxt   = dir_q;
        pat_nxt   = pat_q;
        phase_nxt = phase_q;

        if (btn_edge) begin
            mode_nxt  = next_mode(mode_q);
            phase_nxt = 1'b1;
            dir_nxt   = LEFT;
            pat_nxt   = SEED;
            // An all-zero seed would leave SHIFT permanently dark.
            if (mode_nxt == MODE_SHIFT && sw_s2 != '0) begin
                pat_nxt = sw_s2;
            end
        end else if (step) begin
            case (mode_q)
                MODE_BLINK: begin
                    phase_nxt = ~phase_q;
                end
                MODE_SHIFT: begin
                    pat_nxt = {pat_q[WIDTH-2:0], pat_q[WIDTH-1]};
                end
                MODE_BOUNCE: begin
                    // Turn around by jumping straight to the neighbour so
                    // neither end LED is shown for two ticks.
                    if (dir_q == LEFT) begin
                        if (pat_q == TOP) begin
                            dir_nxt = RIGHT;
                            pat_nxt = TOP >> 1;
                        end else begin
                            pat_nxt = pat_q << 1;
                        end
                    end else begin
                        if (pat_q == SEED) begin
                            dir_nxt = LEFT;
                            pat_nxt = SEED << 1;
                        end else begin
                            pat_nxt = pat_q >> 1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // LED drive is built from the next-state values so that it switches on
    // the same edge as the mode register.
    always_comb begin
        led_nxt = '0;
        case (mode_nxt)
            MODE_PASS:  led_nxt = sw_s2;
            MODE_BLINK: led_nxt = phase_nxt ? sw_s2 : '0;
            default:    led_nxt = pat_nxt;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q  <= MODE_PASS;
            dir_q   <= LEFT;
            pat_q   <= SEED;
            phase_q <= 1'b1;
            led_q   <= '0;
        end else begin
            mode_q  <= mode_nxt;
            dir_q   <= dir_nxt;
            pat_q   <= pat_nxt;
            phase_q <= phase_nxt;
            led_q   <= led_nxt;
        end
    end

    assign led  = led_q;
    assign mode = mode_q;

endmodule

// File: tb/tb_led_mode_ctrl.sv
module tb_led_mode_ctrl;

    localparam int W = 16;

    logic         clk;
    logic         rst_n;
    logic [W-1:0] sw;
    logic         btn_next;
    logic [W-1:0] led;
    logic [1:0]   mode;

    int checks;
    int failures;

    typedef struct {
        logic [W-1:0] led;
        logic [1:0]   mode;
        int           cyc;
    } exp_t;

    exp_t sb[$];

    // model state, updated once per rising edge
    int           m_cnt;
    int           m_entry;
    int           m_mode;
    logic [W-1:0] m_seed;
    logic [W-1:0] swh[4];
    logic         bh[4];

    led_mode_ctrl #(
        .CLK_HZ  (8),
        .TICK_HZ (1),
        .WIDTH   (W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .sw       (sw),
        .btn_next (btn_next),
        .led      (led),
        .mode     (mode)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected LED image from mode and number of pattern steps since entry.
    function automatic logic [W-1:0] model_led(input int md, input int steps,
                                               input logic [W-1:0] swv,
                                               input logic [W-1:0] seed);
        logic [W-1:0] x;
        int s;
        case (md)
            0: return swv;
            1: return (steps % 2 == 0) ? swv : '0;
            2: begin
                x = seed;
                for (int i = 0; i < steps % 16; i++) x = {x[W-2:0], x[W-1]};
                return x;
            end
            default: begin
                s = steps % 30;
                if (s > 15) s = 30 - s;
                x = 16'h0001;
                return x << s;
            end
        endcase
    endfunction

    // Reference model: two-cycle input delay, rise detect, then closed-form
    // pattern from cycles since the last mode entry (8 cycles per step).
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                m_cnt   = 0;
                m_entry = 0;
                m_mode  = 0;
                m_seed  = 16'h0001;
                for (int i = 0; i < 4; i++) begin
                    swh[i] = '0;
                    bh[i]  = 1'b0;
                end
            end else begin
                m_cnt++;
                for (int i = 3; i > 0; i--) begin
                    swh[i] = swh[i-1];
                    bh[i]  = bh[i-1];
                end
                swh[0] = sw;
                bh[0]  = btn_next;
                if (bh[2] && !bh[3]) begin
                    m_mode  = (m_mode + 1) % 4;
                    m_entry = m_cnt;
                    m_seed  = (swh[2] == '0) ? 16'h0001 : swh[2];
                end
                e.led  = model_led(m_mode, (m_cnt - m_entry) / 8, swh[2], m_seed);
                e.mode = 2'(m_mode);
                e.cyc  = m_cnt;
                sb.push_back(e);
            end
        end
    end

    // Monitor
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                checks++;
                if (led !== '0 || mode !== 2'd0) begin
                    failures++;
                    $display("FAIL reset_state led=%h mode=%0d required led=0000 mode=0", led, mode);
                end
                sb.delete();
            end else if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_empty no expected entry at time %0t", $time);
            end else begin
                e = sb.pop_front();
                checks++;
                if (led !== e.led) begin
                    failures++;
                    $display("FAIL led cyc=%0d got=%h required=%h", e.cyc, led, e.led);
                end
                checks++;
                if (mode !== e.mode) begin
                    failures++;
                    $display("FAIL mode cyc=%0d got=%0d required=%0d", e.cyc, mode, e.mode);
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input int hold, input int gap);
        @(negedge clk);
        btn_next = 1'b1;
        repeat (hold) @(negedge clk);
        btn_next = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    // Press so the detected edge lands on the cycle the prescaler is at DIV-1.
    task automatic timed_press();
        int target;
        target = m_entry + 5;
        while (target < m_cnt) target += 8;
        while (m_cnt < target) @(negedge clk);
        btn_next = 1'b1;
        @(negedge clk);
        btn_next = 1'b0;
        idle(4);
    endtask

    task automatic release_reset();
        @(negedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        bit found;
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        btn_next = 1'b0;
        sw       = 16'hA5A5;

        // 1: reset and pass-through
        idle(4);
        release_reset();
        idle(10);
        sw = 16'h1234;
        idle(6);
        for (int i = 0; i < 8; i++) begin
            sw = W'($urandom);
            idle($urandom_range(1, 5));
        end

        // 2: blink
        sw = 16'h00FF;
        idle(3);
        press(1, 4);
        idle(22);
        sw = 16'hFF00;
        idle(12);
        for (int i = 0; i < 5; i++) begin
            sw = W'($urandom);
            idle($urandom_range(2, 9));
        end

        // 3: shift with zero seed, then with 8001
        sw = 16'h0000;
        idle(4);
        press(1, 4);
        idle(140);
        press(2, 4);
        press(1, 4);
        press(3, 4);
        sw = 16'h8001;
        idle(4);
        press(1, 4);
        idle(30);

        // 4: bounce full period
        press(1, 4);
        idle(260);

        // 5: presses coincident with the terminal count, wrap to PASS
        timed_press();
        idle(5);
        sw = W'($urandom);
        timed_press();
        idle(20);
        sw = W'($urandom);
        timed_press();
        idle(20);
        timed_press();
        idle(20);

        // 6: asynchronous reset mid-bounce
        for (int i = 0; i < 4 && m_mode != 3; i++) press(1, 4);
        found = 1'b0;
        for (int i = 0; i < 300 && !found; i++) begin
            @(negedge clk);
            if (led == 16'h0400) found = 1'b1;
        end
        checks++;
        if (!found) begin
            failures++;
            $display("FAIL bounce_0400 not reached within 300 cycles led=%h", led);
        end
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (led !== '0) begin
            failures++;
            $display("FAIL async_rst_led got=%h required=0000", led);
        end
        checks++;
        if (mode !== 2'd0) begin
            failures++;
            $display("FAIL async_rst_mode got=%0d required=0", mode);
        end
        sw = 16'hA5A5;
        idle(3);
        release_reset();
        idle(10);
        sw = 16'h1234;
        idle(6);

        // random mix
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 3))
                0: sw = W'($urandom);
                1: sw = '0;
                2: press($urandom_range(1, 3), $urandom_range(3, 6));
                default: timed_press();
            endcase
            idle($urandom_range(1, 30));
        end
        idle(5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
